// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // True for any data access the memory must not see: illegal size 11,
  // or a half/word not naturally aligned.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_prio.sv
// Grant selection between fetch and data, with a starvation guard for fetch.
module arb_prio #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic d_req,
  input  logic idle,
  output logic grant_if,
  output logic grant_d
);

  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       force_if;

  // Data wins unless fetch has waited through CNT_MAX data grants.
  always_comb begin
    force_if = if_req && (starve_cnt_q == CNT_MAX);
    grant_d  = idle && d_req && !force_if;
    grant_if = idle && if_req && !grant_d;
  end

  // Count data grants that bypass a pending fetch; any idle fetch line clears.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req || grant_if) begin
      starve_cnt_d = '0;
    end else if (grant_d && (starve_cnt_q != CNT_MAX)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_rw,
  input  logic [1:0]  d_size,
  input  logic        d_sign,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  output logic        mem_sign,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

  arb_state_e  state_q, state_d;
  logic [2:0]  lat_q, lat_d;
  logic        own_d_q, own_d_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  mem_size_q, mem_size_d;
  logic        mem_sign_q, mem_sign_d;
  logic        if_rvalid_q, if_rvalid_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        d_rvalid_q, d_rvalid_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        d_err_q, d_err_d;

  logic idle;
  logic grant_if, grant_d;
  logic d_bad;

  // Gating with rst_n keeps grants low while reset is held.
  assign idle  = (state_q == IDLE) && rst_n;
  assign d_bad = is_misaligned(d_size, d_addr[1:0]);

  arb_prio #(
    .STARVE_MAX(STARVE_MAX)
  ) u_prio (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .d_req    (d_req),
    .idle     (idle),
    .grant_if (grant_if),
    .grant_d  (grant_d)
  );

  // Next-state and datapath: latch the winner, issue, count latency, respond.
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    own_d_d     = own_d_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_size_d  = mem_size_q;
    mem_sign_d  = mem_sign_q;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rvalid_d  = 1'b0;
    d_rdata_d   = d_rdata_q;
    d_err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_d) begin
          if (d_bad) begin
            // Rejected without touching memory; answered next cycle.
            d_rvalid_d = 1'b1;
            d_err_d    = 1'b1;
            d_rdata_d  = '0;
          end else begin
            own_d_d     = 1'b1;
            mem_we_d    = d_rw;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_size_d  = d_size;
            mem_sign_d  = d_sign;
            state_d     = ISSUE;
          end
        end else if (grant_if) begin
          own_d_d     = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_size_d  = SZ_WORD;
          mem_sign_d  = 1'b0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        lat_d   = LAT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        if (lat_q == 3'd1) begin
          state_d = IDLE;
          if (own_d_q) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = mem_we_q ? '0 : mem_rdata;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      own_d_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_size_q  <= '0;
      mem_sign_q  <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
      d_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      own_d_q     <= own_d_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_size_q  <= mem_size_d;
      mem_sign_q  <= mem_sign_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rvalid_q  <= d_rvalid_d;
      d_rdata_q   <= d_rdata_d;
      d_err_q     <= d_err_d;
    end
  end

  assign if_gnt    = grant_if;
  assign d_gnt     = grant_d;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;
  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_size  = mem_size_q;
  assign mem_sign  = mem_sign_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=4).
module tb_mem_port_arbiter;

  localparam int unsigned MEM_LAT    = 2;
  localparam int unsigned STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_rw = 1'b0;
  logic [1:0]  d_size = 2'b10;
  logic        d_sign = 1'b0;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we, mem_sign;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_size;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .MEM_LAT(MEM_LAT),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_rw(d_rw),
    .d_size(d_size), .d_sign(d_sign), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_sign(mem_sign),
    .mem_rdata(mem_rdata)
  );

  // Memory model: data appears MEM_LAT cycles after the mem_en cycle.
  logic [7:0]  pipe_v = '0;
  logic [31:0] pipe_a [8];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0050_0093 : (a ^ 32'h5A5A_0000);
  endfunction

  always @(posedge clk) begin
    pipe_v   <= {pipe_v[6:0], mem_en};
    pipe_a[0] <= mem_addr;
    for (int i = 1; i < 8; i++) pipe_a[i] <= pipe_a[i-1];
  end

  assign mem_rdata = pipe_v[MEM_LAT-1] ? memfn(pipe_a[MEM_LAT-1]) : 32'h0;

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [143:0] all_outs();
    return {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
            mem_en, mem_we, mem_addr, mem_wdata, mem_size, mem_sign};
  endfunction

  task automatic test_reset;
    if_req = 1'b1; d_req = 1'b1; d_addr = 32'h2000; if_addr = 32'h100;
    next_cycle();
    @(negedge clk);
    tests++;
    if (all_outs() !== '0) begin
      fails++; $display("FAIL reset_outputs: got %h want 0", all_outs());
    end
    if_req = 1'b0; d_req = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_lone_fetch;
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    tests++;
    if ({if_gnt, d_gnt} !== 2'b10) begin
      fails++; $display("FAIL fetch_gnt: got %b want 10", {if_gnt, d_gnt});
    end
    next_cycle(); if_req = 1'b0;
    @(negedge clk);
    tests++;
    if ({mem_en, mem_we, mem_size, mem_sign, mem_addr} !== {1'b1, 1'b0, 2'b10, 1'b0, 32'h100}) begin
      fails++; $display("FAIL fetch_issue: en=%b we=%b sz=%b sg=%b addr=%h want 1 0 10 0 00000100",
                        mem_en, mem_we, mem_size, mem_sign, mem_addr);
    end
    next_cycle(); @(negedge clk);
    tests++;
    if (mem_en !== 1'b0) begin
      fails++; $display("FAIL fetch_en_once: got %b want 0", mem_en);
    end
    next_cycle(); @(negedge clk);
    tests++;
    if (if_rvalid !== 1'b0) begin
      fails++; $display("FAIL fetch_early_rvalid: got %b want 0", if_rvalid);
    end
    next_cycle(); @(negedge clk);
    tests++;
    if ({if_rvalid, d_rvalid, if_rdata} !== {2'b10, 32'h0050_0093}) begin
      fails++; $display("FAIL fetch_resp: rv=%b drv=%b data=%h want 1 0 00500093",
                        if_rvalid, d_rvalid, if_rdata);
    end
    next_cycle(); @(negedge clk);
    tests++;
    if ({if_rvalid, if_rdata} !== {1'b0, 32'h0050_0093}) begin
      fails++; $display("FAIL fetch_hold: rv=%b data=%h want 0 00500093", if_rvalid, if_rdata);
    end
    next_cycle();
  endtask

  task automatic test_simultaneous;
    if_req = 1'b1; if_addr = 32'h104;
    d_req = 1'b1; d_addr = 32'h2000; d_rw = 1'b0; d_size = 2'b10;
    @(negedge clk);
    tests++;
    if ({if_gnt, d_gnt} !== 2'b01) begin
      fails++; $display("FAIL sim_gnt: got %b want 01", {if_gnt, d_gnt});
    end
    next_cycle(); d_req = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      tests++;
      if (if_gnt !== 1'b0) begin
        fails++; $display("FAIL sim_hold_c%0d: if_gnt got %b want 0", c, if_gnt);
      end
      next_cycle();
    end
    @(negedge clk);
    tests++;
    if ({if_gnt, d_rvalid, d_err, d_rdata} !== {3'b110, 32'h5A5A_2000}) begin
      fails++; $display("FAIL sim_handover: gnt=%b rv=%b err=%b data=%h want 1 1 0 5a5a2000",
                        if_gnt, d_rvalid, d_err, d_rdata);
    end
    next_cycle(); if_req = 1'b0;
    next_cycle(); next_cycle(); next_cycle();
    @(negedge clk);
    tests++;
    if ({if_rvalid, if_rdata} !== {1'b1, 32'h5A5A_0104}) begin
      fails++; $display("FAIL sim_fetch_resp: rv=%b data=%h want 1 5a5a0104", if_rvalid, if_rdata);
    end
    next_cycle();
  endtask

  task automatic test_misaligned;
    logic [31:0] a;
    logic [1:0]  s;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       begin a = 32'h2002; s = 2'b10; end
        1:       begin a = 32'h2000; s = 2'b11; end
        default: begin a = 32'h2001; s = 2'b01; end
      endcase
      d_req = 1'b1; d_addr = a; d_size = s; d_rw = 1'b0;
      @(negedge clk);
      tests++;
      if (d_gnt !== 1'b1) begin
        fails++; $display("FAIL mis%0d_gnt: got %b want 1", k, d_gnt);
      end
      next_cycle(); d_req = 1'b0;
      @(negedge clk);
      tests++;
      if ({d_rvalid, d_err, mem_en, d_rdata} !== {3'b110, 32'h0}) begin
        fails++; $display("FAIL mis%0d_resp: rv=%b err=%b en=%b data=%h want 1 1 0 0",
                          k, d_rvalid, d_err, mem_en, d_rdata);
      end
      next_cycle(); @(negedge clk);
      tests++;
      if ({d_rvalid, d_err, mem_en} !== 3'b000) begin
        fails++; $display("FAIL mis%0d_after: rv=%b err=%b en=%b want 0 0 0",
                          k, d_rvalid, d_err, mem_en);
      end
      next_cycle();
    end
    d_size = 2'b10;
  endtask

  task automatic test_starvation;
    logic [9:0] pat;
    int n, cyc, last;
    pat = 10'b01111_01111;
    n = 0; cyc = 0; last = 0;
    d_req = 1'b1; d_addr = 32'h3000; d_rw = 1'b0; d_size = 2'b10;
    if_req = 1'b1; if_addr = 32'h200;
    while (n < 10 && cyc < 80) begin
      @(negedge clk);
      if (d_gnt || if_gnt) begin
        tests++;
        if ({d_gnt, if_gnt} !== {pat[n], !pat[n]} ||
            (n > 0 && (cyc - last) != int'(MEM_LAT + 2))) begin
          fails++; $display("FAIL starve_g%0d: d=%b if=%b gap=%0d want d=%b gap=%0d",
                            n, d_gnt, if_gnt, cyc - last, pat[n], MEM_LAT + 2);
        end
        last = cyc;
        n++;
      end
      cyc++;
      if (n < 10) next_cycle();
    end
    if (n < 10) begin
      tests++; fails++;
      $display("FAIL starve_timeout: got %0d grants want 10", n);
    end
    next_cycle(); d_req = 1'b0; if_req = 1'b0;
    repeat (5) next_cycle();
  endtask

  task automatic test_store;
    d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h2004; d_wdata = 32'hDEAD_BEEF; d_size = 2'b10;
    @(negedge clk);
    tests++;
    if (d_gnt !== 1'b1) begin
      fails++; $display("FAIL store_gnt: got %b want 1", d_gnt);
    end
    next_cycle(); d_req = 1'b0; d_rw = 1'b0;
    @(negedge clk);
    tests++;
    if ({mem_en, mem_we, mem_wdata, mem_addr} !== {2'b11, 32'hDEAD_BEEF, 32'h2004}) begin
      fails++; $display("FAIL store_issue: en=%b we=%b wd=%h addr=%h want 1 1 deadbeef 00002004",
                        mem_en, mem_we, mem_wdata, mem_addr);
    end
    next_cycle(); next_cycle(); next_cycle();
    @(negedge clk);
    tests++;
    if ({d_rvalid, d_err, d_rdata} !== {2'b10, 32'h0}) begin
      fails++; $display("FAIL store_resp: rv=%b err=%b data=%h want 1 0 0", d_rvalid, d_err, d_rdata);
    end
    next_cycle();
  endtask

  task automatic test_reset_midop;
    d_req = 1'b1; d_addr = 32'h2008; d_rw = 1'b0; d_size = 2'b10;
    @(negedge clk);
    tests++;
    if (d_gnt !== 1'b1) begin
      fails++; $display("FAIL rst_mid_gnt: got %b want 1", d_gnt);
    end
    next_cycle(); d_req = 1'b0;
    next_cycle();
    rst_n = 1'b0; if_req = 1'b1; if_addr = 32'h300;
    #1;
    tests++;
    if (all_outs() !== '0) begin
      fails++; $display("FAIL rst_mid_outputs: got %h want 0", all_outs());
    end
    next_cycle(); next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({if_gnt, d_gnt} !== 2'b10) begin
      fails++; $display("FAIL rst_mid_regrant: got %b want 10", {if_gnt, d_gnt});
    end
    next_cycle(); if_req = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      tests++;
      if ({d_rvalid, if_rvalid} !== 2'b00) begin
        fails++; $display("FAIL rst_mid_quiet_c%0d: drv=%b irv=%b want 0 0", c, d_rvalid, if_rvalid);
      end
      next_cycle();
    end
    @(negedge clk);
    tests++;
    if ({if_rvalid, d_rvalid, if_rdata} !== {2'b10, 32'h5A5A_0300}) begin
      fails++; $display("FAIL rst_mid_fetch: irv=%b drv=%b data=%h want 1 0 5a5a0300",
                        if_rvalid, d_rvalid, if_rdata);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_simultaneous();
    test_misaligned();
    test_starvation();
    test_store();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between the fetch unit and the load/store unit of the RV32I core.
- Each request is a req/gnt/rvalid transaction. The arbiter registers the winning request onto the memory port, waits a fixed memory latency, then returns read data or a write completion to the winner.
- Data accesses have priority over fetch, with a starvation guard for fetch. Size/sign encodings match the core decoder: size 00 byte, 01 half, 10 word; sign 1 signed.

Parameters:
- MEM_LAT, 2, cycles from the mem_en cycle to the cycle mem_rdata is valid. Legal range 1..7.
- STARVE_MAX, 4, consecutive data grants allowed while if_req is pending before fetch is forced to win. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held, with if_addr stable, until if_gnt.
- if_addr  in  32  fetch byte address; word aligned.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  32  fetched instruction.
- d_req  in  1  load/store request; held, with its fields stable, until d_gnt.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data, LSB-aligned.
- d_rw  in  1  0 read, 1 write.
- d_size  in  2  access size.
- d_sign  in  1  load sign-extension; passed through to memory.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  one-cycle completion pulse, for loads and stores.
- d_rdata  out  32  load data; 0 for stores and errors.
- d_err  out  1  qualifies d_rvalid; misaligned access or size 11.
- mem_en  out  1  memory access strobe, one cycle.
- mem_we  out  1  write enable, qualified by mem_en.
- mem_addr  out  32  registered address.
- mem_wdata  out  32  registered write data.
- mem_size  out  2  registered size.
- mem_sign  out  1  registered sign.
- mem_rdata  in  32  memory read data, valid MEM_LAT cycles after mem_en.

Behaviour:
- Reset (async, rst_n=0): state IDLE; starve_cnt=0. Every output is 0: gnt, rvalid, rdata, err, mem_*.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: gnt outputs are combinational from req and state; at most one gnt per cycle.
  - Selection: d_req wins unless if_req=1 and starve_cnt==STARVE_MAX, in which case fetch wins.
  - On grant, mem_addr/mem_wdata/mem_size/mem_sign/mem_we load at the clock edge and the FSM goes to ISSUE.
  - A fetch loads mem_size=10, mem_sign=0, mem_we=0.
- Error check (data grant): d_size=11, or size 10 with addr[1:0]!=0, or size 01 with addr[0]=1.
  - No memory access is made; state stays IDLE.
  - Next cycle: d_rvalid=1, d_err=1, d_rdata=0.
- ISSUE: mem_en=1 for exactly one cycle. Load wait counter = MEM_LAT; go to WAIT.
- WAIT: decrement counter each cycle.
  - In the cycle it reads 1, capture mem_rdata (reads only) into the winner's rdata register and go to IDLE.
  - Next cycle: the winner's rvalid=1 for one cycle.
- Pipelining: rvalid coincides with IDLE, so a new grant may occur in the rvalid cycle.
  - Timing: grant at G, mem_en at G+1, mem_rdata at G+1+MEM_LAT, rvalid at G+2+MEM_LAT.
  - Throughput: one access per MEM_LAT+2 cycles.
- rdata holds its last value between pulses. Stores return rdata=0.
- starve_cnt:
  - +1 (saturating at STARVE_MAX) on each data grant while if_req=1.
  - Cleared on a fetch grant, or on any cycle with if_req=0.
- Requests arriving while not in IDLE are not granted. Requesters keep holding; no request is dropped.
- d_err is 0 whenever d_rvalid is 0.
- Reset mid-transaction: the outstanding access is abandoned with no rvalid. Memory sees no further mem_en.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum IDLE/ISSUE/WAIT;
  - size constants SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - function is_misaligned(size, addr[1:0]).
- One sub-module, arb_prio: combinational grant selection plus the registered starve_cnt. Inputs: if_req, d_req, idle. Outputs: grant_if, grant_d.

Test Plan:
- Lone fetch, MEM_LAT=2: if_req with if_addr=0x100 at cycle 1 -> if_gnt cycle 1; mem_en=1, mem_addr=0x100, mem_we=0 cycle 2; memory drives 0x00500093 cycle 4 -> if_rvalid=1, if_rdata=0x00500093 cycle 5.
- Simultaneous requests: if_req and d_req (load 0x2000, size 10) both at cycle 1 -> d_gnt cycle 1, if_gnt=0; if_gnt cycle 5, same cycle as d_rvalid.
- Store: d_rw=1, addr=0x2004, wdata=0xDEADBEEF, size 10 -> mem_en=1, mem_we=1, mem_wdata=0xDEADBEEF at G+1; d_rvalid=1, d_rdata=0, d_err=0 at G+4.
- Misaligned: d_size=10 with addr=0x2002, and separately d_size=11 -> d_gnt; no mem_en ever; d_rvalid=1, d_err=1 next cycle.
- Starvation, STARVE_MAX=4: d_req and if_req held continuously -> exactly 4 data grants, then if_gnt, then data resumes; the pattern repeats.
- Reset mid-op: drop rst_n during WAIT -> all outputs 0 immediately; no rvalid after release; first request after release is granted in IDLE.
